// File: rtl/data_src_pkg.sv
// Shared types, constants and helpers for the data source generator.
package data_src_pkg;

  // Beat-generation mode latched at burst start.
  typedef enum logic [1:0] {
    COUNT = 2'd0,
    LFSR  = 2'd1,
    CONST = 2'd2
  } mode_e;

  // Burst FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Fibonacci taps x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

  // One LFSR shift: move left, feed parity of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] d);
    return {d[14:0], ^(d & LFSR_TAPS)};
  endfunction

  // Map the raw mode field; the reserved encoding behaves as CONST.
  function automatic mode_e decode_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd0:    r = COUNT;
      2'd1:    r = LFSR;
      2'd2:    r = CONST;
      default: r = CONST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_src_lfsr16.sv
// Registered 16-bit Fibonacci LFSR. Holds the current beat value of an LFSR
// burst and presents the value that follows it, so the owner can load its
// own output register with exactly the same sequence.
module data_src_lfsr16
  import data_src_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] q_next
);

  logic [15:0] lfsr_r;

  // LFSR state: load has priority over advance, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      lfsr_r <= seed;
    end else if (enable) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign q_next = lfsr_next(lfsr_r);

endmodule

// File: rtl/data_src_gen.sv
// Burst data source: emits len beats of counter, LFSR or constant data over
// a valid/ready handshake. data is forced to zero outside an active burst.
module data_src_gen
  import data_src_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                LEN_W  = 8,
  parameter logic [DATA_W-1:0] STEP   = 16'h0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W-1:0] ONE_BEAT  = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO_BEATS = LEN_W'(2);
  localparam logic [LEN_W-1:0] NO_BEATS  = LEN_W'(0);

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;

  state_e            state_r,      state_nxt_s;
  mode_e             mode_r,       mode_nxt_s;
  logic [LEN_W-1:0]  beats_left_r, beats_nxt_s;
  logic [DATA_W-1:0] data_r,       data_nxt_s;
  logic              valid_r,      valid_nxt_s;
  logic              last_r,       last_nxt_s;
  logic              busy_r,       busy_nxt_s;
  logic              done_r,       done_nxt_s;

  logic              handshake_s;
  logic [DATA_W-1:0] seed_eff_s;
  logic              lfsr_load_s;
  logic              lfsr_en_s;
  logic [15:0]       lfsr_q_next_s;

  // Reset synchronizer: asserts immediately, releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  data_src_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (rst_n_s),
    .load    (lfsr_load_s),
    .enable  (lfsr_en_s),
    .seed    (seed_eff_s),
    .q_next  (lfsr_q_next_s)
  );

  // Next-state, beat counter and next output values.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    beats_nxt_s = beats_left_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_en_s   = 1'b0;
    handshake_s = valid_r & ready;
    // An all-zero LFSR would lock up, so substitute the default seed.
    if ((decode_mode(mode) == LFSR) && (seed == 16'h0000)) begin
      seed_eff_s = LFSR_SEED_DEFAULT;
    end else begin
      seed_eff_s = seed;
    end

    case (state_r)
      IDLE: begin
        data_nxt_s  = 16'h0000;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
        if (start) begin
          mode_nxt_s  = decode_mode(mode);
          beats_nxt_s = len;
          lfsr_load_s = 1'b1;
          if (len != NO_BEATS) begin
            state_nxt_s = RUN;
            data_nxt_s  = seed_eff_s;
            valid_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
            last_nxt_s  = (len == ONE_BEAT);
          end else begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        if (abort) begin
          // A coincident handshake still counts; the burst simply stops.
          if (handshake_s) begin
            beats_nxt_s = beats_left_r - ONE_BEAT;
          end else begin
            beats_nxt_s = beats_left_r;
          end
          state_nxt_s = IDLE;
          data_nxt_s  = 16'h0000;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b0;
        end else if (handshake_s) begin
          beats_nxt_s = beats_left_r - ONE_BEAT;
          if (last_r) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
            data_nxt_s  = 16'h0000;
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
            busy_nxt_s  = 1'b0;
          end else begin
            last_nxt_s = (beats_left_r == TWO_BEATS);
            case (mode_r)
              COUNT: data_nxt_s = data_r + STEP;
              LFSR: begin
                data_nxt_s = lfsr_q_next_s;
                lfsr_en_s  = 1'b1;
              end
              CONST:   data_nxt_s = data_r;
              default: data_nxt_s = data_r;
            endcase
          end
        end else begin
          // Back-pressure: everything holds.
          state_nxt_s = RUN;
        end
      end

      DONE: begin
        state_nxt_s = IDLE;
        data_nxt_s  = 16'h0000;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
      end

      default: begin
        state_nxt_s = IDLE;
        data_nxt_s  = 16'h0000;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, parameter and output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= IDLE;
      mode_r       <= COUNT;
      beats_left_r <= NO_BEATS;
      data_r       <= 16'h0000;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mode_r       <= mode_nxt_s;
      beats_left_r <= beats_nxt_s;
      data_r       <= data_nxt_s;
      valid_r      <= valid_nxt_s;
      last_r       <= last_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;
  assign last  = last_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_data_src_gen.sv
// Self-checking bench for data_src_gen: directed and randomized bursts
// checked against an arithmetic reference of the beat sequence.
module tb_data_src_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [7:0]  len;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  data_src_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .seed    (seed),
    .len     (len),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .last    (last),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value of the beat following v in the given mode.
  function automatic logic [15:0] model_step(input logic [1:0] m, input logic [15:0] v);
    logic [15:0] r;
    case (m)
      2'd0:    r = v + 16'd1;
      2'd1:    r = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one burst. rmode: 0 ready always, 1 toggling, 2 random.
  // abort_at: handshake index that carries abort (-1 for none).
  // inj: pulse start mid-burst and again in DONE; both must be ignored.
  task automatic run_burst(input logic [1:0] m, input logic [15:0] sd, input int n,
                           input int rmode, input int abort_at, input bit inj);
    logic [15:0] exp_q[$];
    logic [15:0] v;
    int          nb;
    int          idx;
    int          cyc;
    logic        rdy;

    v = ((m == 2'd1) && (sd == 16'h0000)) ? 16'h0001 : sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = model_step(m, v);
    end
    nb = (abort_at >= 0) ? abort_at + 1 : n;

    mode  = m;
    seed  = sd;
    len   = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;

    if (n == 0) begin
      chk("zero_len_valid", {31'd0, valid}, 32'd0);
      chk("zero_len_done", {31'd0, done}, 32'd1);
      chk("zero_len_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("zero_len_done_off", {31'd0, done}, 32'd0);
      chk("zero_len_valid_off", {31'd0, valid}, 32'd0);
      return;
    end

    chk("first_valid", {31'd0, valid}, 32'd1);
    idx = 0;
    cyc = 0;
    while ((idx < nb) && (cyc < 2000)) begin
      chk("beat_valid", {31'd0, valid}, 32'd1);
      chk("beat_data", {16'd0, data}, {16'd0, exp_q[idx]});
      chk("beat_last", {31'd0, last}, {31'd0, (idx == n - 1)});
      chk("beat_busy", {31'd0, busy}, 32'd1);
      if (inj && (cyc == 2)) begin
        start = 1'b1;
        mode  = 2'd2;
        seed  = 16'hDEAD;
        len   = 8'd3;
      end else begin
        start = 1'b0;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0] ? 1'b0 : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (abort_at == idx) begin
        rdy   = 1'b1;
        abort = 1'b1;
      end
      ready = rdy;
      tick();
      abort = 1'b0;
      start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    chk("cycle_budget", {31'd0, (cyc < 2000)}, 32'd1);
    ready = 1'b0;

    chk("end_valid", {31'd0, valid}, 32'd0);
    chk("end_data", {16'd0, data}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_done", {31'd0, done}, {31'd0, (abort_at < 0)});
    if (inj) begin
      mode  = 2'd0;
      seed  = 16'h4321;
      len   = 8'd5;
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk("done_pulse_off", {31'd0, done}, 32'd0);
    chk("post_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_data", {16'd0, data}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = 2'd0;
    seed    = 16'h0000;
    len     = 8'd0;
    ready   = 1'b0;

    // Reset state.
    #22;
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_data", {16'd0, data}, 32'd0);
    chk("post_rst_valid", {31'd0, valid}, 32'd0);

    // COUNT wrap.
    run_burst(2'd0, 16'hFFFE, 4, 0, -1, 1'b0);
    // LFSR with zero seed and toggling ready.
    run_burst(2'd1, 16'h0000, 3, 1, -1, 1'b0);
    // Zero length.
    run_burst(2'd0, 16'h5555, 0, 0, -1, 1'b0);
    // Start ignored while busy and in DONE.
    run_burst(2'd0, 16'h0100, 10, 2, -1, 1'b1);
    // Abort on the third handshake.
    run_burst(2'd2, 16'hA5A5, 8, 0, 2, 1'b0);
    // Full length with random ready.
    run_burst(2'd0, 16'h0000, 255, 2, -1, 1'b0);
    // Randomized bursts, including the reserved mode.
    for (int k = 0; k < 12; k++) begin
      int n;
      int ab;
      n  = $urandom_range(1, 12);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_burst(2'($urandom_range(0, 3)), 16'($urandom), n, 2, ab, 1'b0);
    end

    // Reset mid-burst clears outputs immediately and does not resume.
    mode  = 2'd0;
    seed  = 16'h1234;
    len   = 8'd8;
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_data_before", {16'd0, data}, 32'h0000_1234);
    chk("mid_valid_before", {31'd0, valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", {16'd0, data}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_last", {31'd0, last}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rel_data", {16'd0, data}, 32'd0);
      chk("rel_valid", {31'd0, valid}, 32'd0);
      chk("rel_busy", {31'd0, busy}, 32'd0);
    end
    ready = 1'b0;
    // Normal operation after reset release.
    run_burst(2'd1, 16'hACE1, 5, 2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_src_gen.md
Name: data_src_gen

Overview:
- Producer of the 16-bit `data` bus that the codebase's reset/data property checker monitors.
- Generates bursts of beats in counter, LFSR or constant mode over a valid/ready handshake.
- Forces `data` to 16'h0 whenever reset is asserted or no burst is active, so the data-zero-after-reset property holds by construction.
- Sits between test/config control logic and any consumer of `data`.

Parameters:
- DATA_W, 16, width of data; only 16 is supported (the LFSR polynomial is fixed).
- LEN_W, 8, width of the burst-length field.
- STEP, 16'h0001, increment applied per beat in counter mode.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse requesting a burst; sampled in IDLE only.
- abort  input  1  terminates the active burst.
- mode  input  2  0=COUNT, 1=LFSR, 2=CONST, 3=reserved (treated as CONST); latched on start.
- seed  input  DATA_W  first beat value; latched on start.
- len  input  LEN_W  number of beats; latched on start.
- data  output  DATA_W  current beat value.
- valid  output  1  beat available.
- ready  input  1  consumer accepts the beat.
- last  output  1  high with the final beat of a burst.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after normal completion.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; data=0, valid=0, last=0, busy=0, done=0.
  - Internal beat counter and mode register cleared.
- IDLE:
  - data=0, valid=0.
  - start=1 latches mode, seed and len.
  - If len!=0, go to RUN; data=seed and valid=1 from the next cycle (latency 1 cycle start→valid).
  - If len==0, no beats are issued; go to DONE (done=1 on the next cycle).
- RUN:
  - busy=1, valid=1.
  - Handshake occurs when valid && ready.
  - While valid && !ready, data and last are held stable (no change allowed).
  - On each handshake:
    - beats_left decrements.
    - COUNT: data <= data + STEP, modulo 2^16; wrap 16'hFFFF+1 → 16'h0000, no flag.
    - LFSR: Fibonacci, taps x^16+x^14+x^13+x^11+1; shift left, feedback bit = d[15]^d[13]^d[12]^d[10], inserted at bit 0. A seed of 0 in LFSR mode is replaced by 16'h0001 at latch time.
    - CONST: data unchanged.
  - last=1 exactly while beats_left==1.
  - A handshake with last=1 goes to DONE.
- DONE:
  - Lasts one cycle: done=1, valid=0, busy=0, data=0.
  - Then IDLE.
  - A start in DONE is ignored.
- abort:
  - In RUN: next state IDLE, with valid=0 and data=0 next cycle; no done pulse.
  - If abort and a handshake coincide, that beat counts as transferred, then IDLE.
  - Ignored outside RUN.
- start while busy or in DONE: ignored, with no effect on latched parameters.
- Reset mid-burst: all outputs return to reset values immediately (asynchronously). After release, state is IDLE; the burst is not resumed.
- len = 2^LEN_W-1 (255): exactly 255 beats.
- All state updates occur on posedge clk only; there are no combinational paths from inputs to outputs.

Decomposition:
- Package data_src_pkg holds:
  - mode_e enum (COUNT, LFSR, CONST).
  - state_e enum (IDLE, RUN, DONE).
  - LFSR_TAPS constant 16'hB400.
  - LFSR_SEED_DEFAULT constant 16'h0001.
  - Function lfsr_next(input logic [15:0]).
- Sub-module data_src_lfsr16: registered LFSR with load/enable, used by data_src_gen in LFSR mode.
- The FSM, beat counter and output mux stay in data_src_gen.

Test Plan:
- Reset check: reset_n low mid-RUN with data=16'h1234 → data=0, valid=0, busy=0 immediately; after release, state IDLE and data stays 0 until start.
- COUNT burst: mode=0, seed=16'hFFFE, len=4, ready=1 → beats FFFE, FFFF, 0000, 0001; last on beat 4; done one cycle after; valid first seen 1 cycle after start.
- LFSR burst with back-pressure:
  - mode=1, seed=0, len=3 → first beat 16'h0001, then lfsr_next chain (0002, 0004).
  - ready toggling 1/0 → data held stable on every ready=0 cycle.
- Zero length and ignored start: len=0 → no valid; done 1 cycle after start. A second start while busy in a len=10 burst → exactly 10 beats and latched seed unchanged.
- Abort: CONST seed=16'hA5A5, len=8, abort coincident with 3rd handshake → 3 beats counted, then valid=0, data=0, no done pulse.
- Full length: COUNT seed=0, len=255, random ready → exactly 255 beats, final value 16'h00FE with last=1, one done pulse.
